// File: rtl/obstacle_track.sv
// Obstacle slot tracker: accepts spawn requests, scrolls live obstacles left,
// renders them as a palette-index stream and latches player overlap.
module obstacle_track #(
    parameter int NSLOT = 4,
    parameter int CIDXW = 3,
    parameter int X_START = 750,
    parameter int X_END = 170,
    parameter int OBS_W = 16,
    parameter int OBS_H = 16,
    parameter int SPEED = 4,
    parameter int MIN_GAP = 96,
    parameter logic [CIDXW:0] OBS_COLOR = 4'b0100
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       state,
    input  logic             scroll_tick,
    input  logic             spawn_valid,
    input  logic [1:0]       spawn_loc,
    output logic             spawn_ready,
    input  logic [9:0]       hc,
    input  logic [9:0]       vc,
    input  logic             player_pix_on,
    output logic [CIDXW:0]   obs_pix,
    output logic             collision,
    output logic [2:0]       active_count
);

    localparam int IDXW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [9:0] X_ST = 10'(X_START);
    localparam logic [9:0] X_RETIRE = 10'(X_END + SPEED);
    localparam logic [9:0] GAP_X = 10'(X_START - MIN_GAP);
    localparam logic [9:0] SPD = 10'(SPEED);
    localparam logic [10:0] W_M1 = 11'(OBS_W - 1);
    localparam logic [9:0] H_M1 = 10'(OBS_H - 1);

    logic [NSLOT-1:0] valid_q, valid_d;
    logic [9:0]       x_q [NSLOT];
    logic [9:0]       x_d [NSLOT];
    logic [1:0]       loc_q [NSLOT];
    logic [1:0]       loc_d [NSLOT];
    logic [9:0]       newest_x_q, newest_x_d;

    logic            running, title;
    logic            free_found;
    logic [IDXW-1:0] free_idx;
    logic            accept, alloc, do_scroll;
    logic            any_hit;
    logic [3:0]      pop;

    // Top row of each lane; lanes are stacked upward from the ground line.
    function automatic logic [9:0] band_top(input logic [1:0] loc);
        unique case (loc)
            2'd2:    band_top = 10'd268;
            2'd3:    band_top = 10'd244;
            default: band_top = 10'd292;
        endcase
    endfunction

    assign running = (state >= 4'd5) && (state <= 4'd10);
    assign title = (state == 4'd0);

    always_comb begin
        free_found = 1'b0;
        free_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx = IDXW'(i);
            end
        end
    end

    assign spawn_ready = running
                       && (free_found || spawn_loc == 2'd0)
                       && (!(|valid_q) || newest_x_q <= GAP_X);
    assign accept = spawn_valid && spawn_ready;
    assign alloc = accept && (spawn_loc != 2'd0);
    assign do_scroll = scroll_tick && running;

    // Allocation uses the pre-scroll free map, so a slot retiring this
    // cycle only becomes available on the next one.
    always_comb begin
        valid_d = valid_q;
        newest_x_d = newest_x_q;
        for (int i = 0; i < NSLOT; i++) begin
            x_d[i] = x_q[i];
            loc_d[i] = loc_q[i];
        end
        if (title) begin
            valid_d = '0;
            newest_x_d = '0;
            for (int i = 0; i < NSLOT; i++) begin
                x_d[i] = '0;
                loc_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (do_scroll && valid_q[i]) begin
                    if (x_q[i] >= X_RETIRE)
                        x_d[i] = x_q[i] - SPD;
                    else
                        valid_d[i] = 1'b0;
                end
                if (alloc && free_idx == IDXW'(i)) begin
                    valid_d[i] = 1'b1;
                    x_d[i] = X_ST;
                    loc_d[i] = spawn_loc;
                end
            end
            if (alloc)
                newest_x_d = X_ST;
            else if (do_scroll)
                newest_x_d = (newest_x_q >= SPD) ? newest_x_q - SPD : '0;
        end
    end

    always_comb begin
        any_hit = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (valid_q[i]
                && {1'b0, hc} >= {1'b0, x_q[i]}
                && {1'b0, hc} <= {1'b0, x_q[i]} + W_M1
                && vc >= band_top(loc_q[i])
                && vc <= band_top(loc_q[i]) + H_M1)
                any_hit = 1'b1;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NSLOT; i++)
            pop = pop + 4'(valid_q[i]);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_q <= '0;
            newest_x_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                x_q[i] <= '0;
                loc_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            newest_x_q <= newest_x_d;
            for (int i = 0; i < NSLOT; i++) begin
                x_q[i] <= x_d[i];
                loc_q[i] <= loc_d[i];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            obs_pix <= '0;
            collision <= 1'b0;
            active_count <= '0;
        end else begin
            obs_pix <= (running && any_hit) ? OBS_COLOR : '0;
            if (title)
                collision <= 1'b0;
            else if (running && obs_pix != '0 && player_pix_on)
                collision <= 1'b1;
            active_count <= 3'(pop);
        end
    end

endmodule

// File: tb/tb_obstacle_track.sv
// Directed bench for obstacle_track: spawn pacing, scroll/retire, render
// window edges, collision latching and state gating.
module tb_obstacle_track;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] state;
    logic       scroll_tick;
    logic       spawn_valid;
    logic [1:0] spawn_loc;
    logic       spawn_ready;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       player_pix_on;
    logic [3:0] obs_pix;
    logic       collision;
    logic [2:0] active_count;

    int n_cmp = 0;
    int n_bad = 0;

    obstacle_track dut (
        .Clk(Clk),
        .Reset(Reset),
        .state(state),
        .scroll_tick(scroll_tick),
        .spawn_valid(spawn_valid),
        .spawn_loc(spawn_loc),
        .spawn_ready(spawn_ready),
        .hc(hc),
        .vc(vc),
        .player_pix_on(player_pix_on),
        .obs_pix(obs_pix),
        .collision(collision),
        .active_count(active_count)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            scroll_tick = 1'b1;
            step();
            scroll_tick = 1'b0;
        end
    endtask

    task automatic spawn(input logic [1:0] loc);
        spawn_valid = 1'b1;
        spawn_loc = loc;
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        state = 4'd0;
        scroll_tick = 1'b0;
        spawn_valid = 1'b0;
        spawn_loc = 2'd0;
        hc = '0;
        vc = '0;
        player_pix_on = 1'b0;
        step();
        step();
        n_cmp++;
        if (obs_pix !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_obs_pix got %0d want 0", obs_pix);
        end
        n_cmp++;
        if (collision !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_collision got %0b want 0", collision);
        end
        n_cmp++;
        if (active_count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_count got %0d want 0", active_count);
        end
        n_cmp++;
        if (spawn_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready got %0b want 0", spawn_ready);
        end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_spawn_gap();
        state = 4'd5;
        spawn_valid = 1'b1;
        spawn_loc = 2'd1;
        #1;
        n_cmp++;
        if (spawn_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL first_ready got %0b want 1", spawn_ready);
        end
        step();
        spawn_valid = 1'b0;
        n_cmp++;
        if (spawn_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_after_spawn got %0b want 0", spawn_ready);
        end
        step();
        n_cmp++;
        if (active_count !== 3'd1) begin
            n_bad++;
            $display("FAIL count_one got %0d want 1", active_count);
        end
        ticks(14);
        n_cmp++;
        if (spawn_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_tick14 got %0b want 0", spawn_ready);
        end
        ticks(9);
        n_cmp++;
        if (spawn_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_tick23 got %0b want 0", spawn_ready);
        end
        ticks(1);
        n_cmp++;
        if (spawn_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_tick24 got %0b want 1", spawn_ready);
        end
    endtask

    // slot0 at 654 on entry; ends with x = 366/462/558/654 (low/mid/high/low)
    task automatic test_fill();
        spawn(2'd2);
        ticks(24);
        spawn(2'd3);
        ticks(24);
        spawn(2'd1);
        ticks(24);
        n_cmp++;
        if (active_count !== 3'd4) begin
            n_bad++;
            $display("FAIL fill_count got %0d want 4", active_count);
        end
        spawn_valid = 1'b1;
        spawn_loc = 2'd2;
        #1;
        n_cmp++;
        if (spawn_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready got %0b want 0", spawn_ready);
        end
        spawn_loc = 2'd0;
        #1;
        n_cmp++;
        if (spawn_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL loc0_ready got %0b want 1", spawn_ready);
        end
        step();
        spawn_valid = 1'b0;
        step();
        n_cmp++;
        if (active_count !== 3'd4) begin
            n_bad++;
            $display("FAIL loc0_count got %0d want 4", active_count);
        end
    endtask

    task automatic test_render();
        logic [9:0] th [12];
        logic [9:0] tv [12];
        logic [3:0] te [12];
        th = '{10'd365, 10'd366, 10'd381, 10'd382, 10'd371, 10'd371,
               10'd371, 10'd371, 10'd470, 10'd470, 10'd560, 10'd560};
        tv = '{10'd300, 10'd300, 10'd300, 10'd300, 10'd291, 10'd292,
               10'd307, 10'd308, 10'd275, 10'd267, 10'd250, 10'd260};
        te = '{4'd0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd4,
               4'd4, 4'd0, 4'd4, 4'd0, 4'd4, 4'd0};
        hc = '0;
        vc = '0;
        step();
        hc = 10'd371;
        vc = 10'd300;
        #1;
        n_cmp++;
        if (obs_pix !== 4'd0) begin
            n_bad++;
            $display("FAIL render_latency got %0d want 0", obs_pix);
        end
        step();
        n_cmp++;
        if (obs_pix !== 4'd4) begin
            n_bad++;
            $display("FAIL render_hit got %0d want 4", obs_pix);
        end
        for (int i = 0; i < 12; i++) begin
            hc = th[i];
            vc = tv[i];
            step();
            n_cmp++;
            if (obs_pix !== te[i]) begin
                n_bad++;
                $display("FAIL render_%0d hc=%0d vc=%0d got %0d want %0d",
                         i, hc, vc, obs_pix, te[i]);
            end
        end
    endtask

    task automatic test_retire();
        ticks(49);
        spawn_valid = 1'b1;
        spawn_loc = 2'd2;
        #1;
        n_cmp++;
        if (spawn_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL retire_full_ready got %0b want 0", spawn_ready);
        end
        spawn_valid = 1'b0;
        ticks(1);
        n_cmp++;
        if (active_count !== 3'd4) begin
            n_bad++;
            $display("FAIL retire_count_lag got %0d want 4", active_count);
        end
        n_cmp++;
        if (spawn_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL retire_ready got %0b want 1", spawn_ready);
        end
        hc = 10'd175;
        vc = 10'd300;
        step();
        n_cmp++;
        if (active_count !== 3'd3) begin
            n_bad++;
            $display("FAIL retire_count got %0d want 3", active_count);
        end
        n_cmp++;
        if (obs_pix !== 4'd0) begin
            n_bad++;
            $display("FAIL retired_pix got %0d want 0", obs_pix);
        end
        hc = 10'd460;
        step();
        n_cmp++;
        if (obs_pix !== 4'd4) begin
            n_bad++;
            $display("FAIL slot3_pix got %0d want 4", obs_pix);
        end
    endtask

    task automatic test_back_to_back();
        spawn_valid = 1'b1;
        spawn_loc = 2'd2;
        scroll_tick = 1'b1;
        step();
        spawn_valid = 1'b0;
        scroll_tick = 1'b0;
        n_cmp++;
        if (spawn_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reuse_ready got %0b want 0", spawn_ready);
        end
        hc = 10'd750;
        vc = 10'd270;
        step();
        n_cmp++;
        if (obs_pix !== 4'd4) begin
            n_bad++;
            $display("FAIL new_at_start got %0d want 4", obs_pix);
        end
        n_cmp++;
        if (active_count !== 3'd4) begin
            n_bad++;
            $display("FAIL reuse_count got %0d want 4", active_count);
        end
        hc = 10'd749;
        step();
        n_cmp++;
        if (obs_pix !== 4'd0) begin
            n_bad++;
            $display("FAIL new_not_scrolled got %0d want 0", obs_pix);
        end
    endtask

    // slot3 (low) sits at x=450 here
    task automatic test_collision_state();
        hc = '0;
        vc = '0;
        player_pix_on = 1'b1;
        step();
        step();
        n_cmp++;
        if (collision !== 1'b0) begin
            n_bad++;
            $display("FAIL no_overlap got %0b want 0", collision);
        end
        player_pix_on = 1'b0;
        hc = 10'd455;
        vc = 10'd300;
        step();
        player_pix_on = 1'b1;
        step();
        player_pix_on = 1'b0;
        n_cmp++;
        if (collision !== 1'b1) begin
            n_bad++;
            $display("FAIL overlap got %0b want 1", collision);
        end
        state = 4'd11;
        step();
        n_cmp++;
        if (obs_pix !== 4'd0) begin
            n_bad++;
            $display("FAIL idle_pix got %0d want 0", obs_pix);
        end
        n_cmp++;
        if (collision !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_sticky got %0b want 1", collision);
        end
        ticks(3);
        state = 4'd5;
        hc = 10'd449;
        step();
        n_cmp++;
        if (obs_pix !== 4'd0) begin
            n_bad++;
            $display("FAIL frozen_left got %0d want 0", obs_pix);
        end
        hc = 10'd450;
        step();
        n_cmp++;
        if (obs_pix !== 4'd4) begin
            n_bad++;
            $display("FAIL frozen_edge got %0d want 4", obs_pix);
        end
        state = 4'd0;
        step();
        n_cmp++;
        if (collision !== 1'b0) begin
            n_bad++;
            $display("FAIL title_coll got %0b want 0", collision);
        end
        step();
        n_cmp++;
        if (active_count !== 3'd0) begin
            n_bad++;
            $display("FAIL title_count got %0d want 0", active_count);
        end
    endtask

    task automatic test_reset_midframe();
        state = 4'd5;
        spawn(2'd1);
        ticks(24);
        spawn(2'd1);
        ticks(24);
        spawn(2'd1);
        hc = 10'd560;
        vc = 10'd300;
        player_pix_on = 1'b1;
        step();
        step();
        n_cmp++;
        if (active_count !== 3'd3) begin
            n_bad++;
            $display("FAIL mid_count got %0d want 3", active_count);
        end
        n_cmp++;
        if (collision !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_coll got %0b want 1", collision);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (obs_pix !== 4'd0 || collision !== 1'b0 || active_count !== 3'd0) begin
            n_bad++;
            $display("FAIL async_reset got pix=%0d coll=%0b cnt=%0d want 0/0/0",
                     obs_pix, collision, active_count);
        end
        state = 4'd0;
        spawn_loc = 2'd0;
        player_pix_on = 1'b0;
        step();
        n_cmp++;
        if (spawn_ready !== 1'b0 || active_count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_hold got rdy=%0b cnt=%0d want 0/0",
                     spawn_ready, active_count);
        end
        Reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_spawn_gap();
        test_fill();
        test_render();
        test_retire();
        test_back_to_back();
        test_collision_state();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
